pr_swap_sequencer: RTL and testbench

- Controller that sequences one partial-reconfiguration swap of a reconfigurable partition (RP) in the PR video pipeline.
- On a start request from the PR_Control register file it:
  - waits for a video frame boundary on the RP's input AXI4-Stream;
  - decouples the RP;
  - requests the bitstream load;
  - pulses the RP reset;
  - re-couples the RP.
- It sits between the PR_Control AXI4-Lite register block (start/clear/status) and the RP decoupler, RP reset and PCAP/ICAP loader handshake.

---
 rtl/pr_swap_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pr_swap_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_swap_sequencer.sv
// Sequences one partial-reconfiguration swap of a reconfigurable partition:
// wait for a frame boundary, decouple, load the bitstream, reset the RP, re-couple.
module pr_swap_sequencer #(
  parameter int LINES_PER_FRAME = 480,
  parameter int LINE_CNT_W      = 12,
  parameter int RST_CYCLES      = 16,
  parameter int SETTLE_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES  = 16777215,
  parameter int TO_W            = 24
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       start_i,
  input  logic       clear_i,
  input  logic       mon_tvalid,
  input  logic       mon_tready,
  input  logic       mon_tlast,
  input  logic       mon_tuser,
  input  logic       load_done_i,
  input  logic       load_err_i,
  output logic       decouple_o,
  output logic       rp_resetn_o,
  output logic       load_req_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_DECOUPLE = 3'd2,
    ST_LOAD     = 3'd3,
    ST_RESET    = 3'd4,
    ST_RELEASE  = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } state_e;

  localparam logic [LINE_CNT_W-1:0] LINES_FULL  = LINE_CNT_W'(LINES_PER_FRAME);
  localparam logic [TO_W-1:0]       TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]       RST_LAST    = TO_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]       SETTLE_LAST = TO_W'(SETTLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [TO_W-1:0]         cnt_q, cnt_d;
  logic [LINE_CNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic                    decouple_q, decouple_d;
  logic                    rp_resetn_q, rp_resetn_d;
  logic                    load_req_q, load_req_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    hs;
  logic                    sof_hs;
  logic                    frame_boundary;

  // The monitored stream is observed only: a beat transfers in a cycle where
  // mon_tvalid and mon_tready are both high; neither is ever driven here.
  assign hs             = mon_tvalid & mon_tready;
  assign sof_hs         = hs & mon_tuser;
  assign frame_boundary = (line_cnt_q == LINES_FULL) && !sof_hs;

  always_comb begin
    line_cnt_d = line_cnt_q;
    if (state_d == ST_RELEASE && state_q != ST_RELEASE) begin
      line_cnt_d = '0;
    end else if (sof_hs) begin
      line_cnt_d = mon_tlast ? LINE_CNT_W'(1) : '0;
    end else if (hs && mon_tlast && line_cnt_q != LINES_FULL) begin
      line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (start_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (frame_boundary)        state_d = ST_DECOUPLE;
        else if (cnt_q == TO_LAST) state_d = ST_ERROR;
      end
      ST_DECOUPLE: state_d = ST_LOAD;
      ST_LOAD: begin
        if (load_err_i)            state_d = ST_ERROR;
        else if (load_done_i)      state_d = ST_RESET;
        else if (cnt_q == TO_LAST) state_d = ST_ERROR;
      end
      ST_RESET:    if (cnt_q == RST_LAST)    state_d = ST_RELEASE;
      ST_RELEASE:  if (cnt_q == SETTLE_LAST) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      ST_ERROR:    if (clear_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // One counter serves the drain/load timeout and the reset/settle delays.
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q inside {ST_DRAIN, ST_LOAD, ST_RESET, ST_RELEASE})) begin
      cnt_d = cnt_q + TO_W'(1);
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    decouple_d  = 1'b0;
    rp_resetn_d = 1'b1;
    load_req_d  = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_d)
      ST_IDLE:     busy_d = 1'b0;
      ST_DECOUPLE: decouple_d = 1'b1;
      ST_LOAD: begin
        decouple_d = 1'b1;
        load_req_d = 1'b1;
      end
      ST_RESET: begin
        decouple_d  = 1'b1;
        rp_resetn_d = 1'b0;
      end
      ST_DONE:     done_d = 1'b1;
      ST_ERROR: begin
        busy_d      = 1'b0;
        decouple_d  = 1'b1;
        rp_resetn_d = 1'b0;
        err_d       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      line_cnt_q  <= '0;
      decouple_q  <= 1'b0;
      rp_resetn_q <= 1'b0;
      load_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_cnt_q  <= line_cnt_d;
      decouple_q  <= decouple_d;
      rp_resetn_q <= rp_resetn_d;
      load_req_q  <= load_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign decouple_o  = decouple_q;
  assign rp_resetn_o = rp_resetn_q;
  assign load_req_o  = load_req_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pr_swap_sequencer.sv
// Bench for pr_swap_sequencer: table vectors, directed multi-cycle sequences,
// and random traffic checked against a timeline model of the swap.
module tb_pr_swap_sequencer;

  localparam int LPF    = 4;
  localparam int RST    = 16;
  localparam int SETTLE = 8;
  localparam int TO     = 100;

  // Input vector bits: {start, clear, tvalid, tready, tlast, tuser, load_done, load_err}
  localparam logic [7:0] I_START = 8'h80;
  localparam logic [7:0] I_CLEAR = 8'h40;
  localparam logic [7:0] I_VAL   = 8'h20;
  localparam logic [7:0] I_RDY   = 8'h10;
  localparam logic [7:0] I_HS    = 8'h30;
  localparam logic [7:0] I_LAST  = 8'h08;
  localparam logic [7:0] I_SOF   = 8'h04;
  localparam logic [7:0] I_LDONE = 8'h02;
  localparam logic [7:0] I_LERR  = 8'h01;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       start_i = 1'b0, clear_i = 1'b0;
  logic       mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0, mon_tuser = 1'b0;
  logic       load_done_i = 1'b0, load_err_i = 1'b0;
  logic       decouple_o, rp_resetn_o, load_req_o, busy_o, done_o, err_o;
  logic [2:0] state_o;

  pr_swap_sequencer #(
    .LINES_PER_FRAME(LPF), .LINE_CNT_W(12), .RST_CYCLES(RST),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO), .TO_W(24)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start_i(start_i), .clear_i(clear_i),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .mon_tuser(mon_tuser), .load_done_i(load_done_i), .load_err_i(load_err_i),
    .decouple_o(decouple_o), .rp_resetn_o(rp_resetn_o), .load_req_o(load_req_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [7:0] in);
    {start_i, clear_i, mon_tvalid, mon_tready, mon_tlast, mon_tuser, load_done_i, load_err_i} = in;
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    drive(8'h00);
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    tick();
  endtask

  task automatic send_frame_lines();
    for (int i = 0; i < LPF; i++) begin
      drive(I_HS | I_LAST | ((i == 0) ? I_SOF : 8'h00));
      tick();
    end
    drive(8'h00);
  endtask

  function automatic logic [8:0] outs_vec();
    return {state_o, decouple_o, rp_resetn_o, load_req_o, busy_o, done_o, err_o};
  endfunction

  // Output values each state is defined to show.
  function automatic logic [8:0] exp_vec(input logic [2:0] st);
    logic dec, rstn, req, busy, done, err;
    dec  = (st == 3'd2) || (st == 3'd3) || (st == 3'd4) || (st == 3'd7);
    rstn = !((st == 3'd4) || (st == 3'd7));
    req  = (st == 3'd3);
    busy = !((st == 3'd0) || (st == 3'd7));
    done = (st == 3'd6);
    err  = (st == 3'd7);
    return {st, dec, rstn, req, busy, done, err};
  endfunction

  // ---------------- table vectors ----------------
  typedef struct {
    logic [7:0] in;
    logic [2:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] in, input logic [2:0] st);
    vec_t v;
    v.in = in;
    v.exp_state = st;
    vecs.push_back(v);
  endtask

  task automatic run_table();
    add(I_START,                     3'd1);
    add(I_HS | I_SOF | I_LAST,       3'd1);
    add(I_HS | I_LAST,               3'd1);
    add(I_HS | I_LAST,               3'd1);
    add(I_HS | I_LAST,               3'd1);  // frame complete
    add(I_HS | I_SOF,                3'd1);  // next SOF in the boundary cycle
    add(I_HS | I_LAST,               3'd1);
    add(I_HS | I_LAST,               3'd1);
    add(I_VAL | I_LAST | I_LDONE,    3'd1);  // no handshake, load_done ignored
    add(I_RDY | I_LAST | I_LERR,     3'd1);  // no handshake, load_err ignored
    add(I_HS | I_LAST,               3'd1);
    add(I_START | I_HS | I_LAST,     3'd1);
    add(I_CLEAR,                     3'd2);
    add(8'h00,                       3'd3);
    add(I_LDONE | I_LERR,            3'd7);
    add(8'h00,                       3'd7);
    add(I_START | I_CLEAR,           3'd0);
    add(8'h00,                       3'd0);
    add(I_LDONE,                     3'd0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in);
      tick();
      check($sformatf("vec%0d", i), outs_vec(), exp_vec(vecs[i].exp_state));
    end
    drive(8'h00);
  endtask

  // ---------------- directed sequences ----------------
  task automatic run_nominal();
    int cyc, tl4, dec_rise, dec_fall, req_rise, rst_fall, rst_rise, done_cyc, n_done, rst_low, n_seq;
    logic [7:0]  in;
    logic [2:0]  last_st;
    logic [31:0] seq_p;
    logic        p_dec, p_req, p_rstn;
    do_reset();
    cyc = 0; tl4 = -1; dec_rise = -1; dec_fall = -1; req_rise = -1;
    rst_fall = -1; rst_rise = -1; done_cyc = -1; n_done = 0; rst_low = 0;
    n_seq = 0; seq_p = '0; last_st = state_o;
    p_dec = decouple_o; p_req = load_req_o; p_rstn = rp_resetn_o;
    for (int k = 0; k < 120; k++) begin
      in = 8'h00;
      if (k == 0) in = I_START;
      else if (k <= LPF) in = I_HS | I_LAST | ((k == 1) ? I_SOF : 8'h00);
      if (req_rise >= 0 && cyc == req_rise + 19) in |= I_LDONE;
      drive(in);
      tick();
      cyc++;
      if (k == LPF) tl4 = cyc;
      if (decouple_o && !p_dec && dec_rise < 0) dec_rise = cyc;
      if (!decouple_o && p_dec && dec_fall < 0) dec_fall = cyc;
      if (load_req_o && !p_req && req_rise < 0) req_rise = cyc;
      if (!rp_resetn_o) rst_low++;
      if (!rp_resetn_o && p_rstn && rst_fall < 0) rst_fall = cyc;
      if (rp_resetn_o && !p_rstn && rst_rise < 0) rst_rise = cyc;
      if (done_o) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (state_o != last_st) begin
        seq_p = {seq_p[28:0], state_o};
        n_seq++;
        last_st = state_o;
      end
      p_dec = decouple_o; p_req = load_req_o; p_rstn = rp_resetn_o;
    end
    drive(8'h00);
    check("nom_dec_rise", dec_rise, tl4 + 1);
    check("nom_load_wait", rst_fall - req_rise, 20);
    check("nom_rst_low_cycles", rst_low, RST);
    check("nom_dec_fall_at_release", dec_fall, rst_rise);
    check("nom_done_after_release", done_cyc - dec_fall, SETTLE);
    check("nom_done_count", n_done, 1);
    check("nom_latency", done_cyc - dec_rise, 1 + 20 + RST + SETTLE);
    check("nom_seq_len", n_seq, 7);
    check("nom_state_seq", seq_p, {11'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0});
  endtask

  task automatic run_timeouts();
    int n;
    do_reset();
    drive(I_START); tick(); drive(8'h00);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (state_o != 3'd1) break;
      n++;
      tick();
    end
    check("to_drain_cycles", n, TO);
    check("to_drain_error", outs_vec(), exp_vec(3'd7));
    drive(I_CLEAR); tick(); drive(8'h00);
    check("to_drain_clear", outs_vec(), exp_vec(3'd0));

    do_reset();
    send_frame_lines();
    drive(I_START); tick(); drive(8'h00);
    for (int k = 0; k < 5; k++) begin
      if (state_o == 3'd3) break;
      tick();
    end
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (state_o != 3'd3) break;
      n++;
      tick();
    end
    check("to_load_cycles", n, TO);
    check("to_load_error", outs_vec(), exp_vec(3'd7));
  endtask

  task automatic run_robustness();
    int n_done, n_load;
    logic [7:0] in;
    do_reset();
    send_frame_lines();
    drive(I_START); tick();
    n_done = 0; n_load = 0;
    for (int k = 0; k < 100; k++) begin
      in = 8'h00;
      if (state_o == 3'd3) begin
        n_load++;
        if (n_load <= 3) in |= I_START;
        if (n_load == 6) in |= I_LDONE;
      end
      drive(in);
      tick();
      if (done_o) n_done++;
    end
    drive(8'h00);
    check("rob_done_count", n_done, 1);
    check("rob_idle_after", outs_vec(), exp_vec(3'd0));

    send_frame_lines();
    drive(I_START); tick();
    for (int k = 0; k < 100; k++) begin
      if (state_o == 3'd4) break;
      drive((state_o == 3'd3) ? I_LDONE : 8'h00);
      tick();
    end
    drive(8'h00);
    check("rob_reached_reset", state_o, 3'd4);
    #2 ARESETN = 1'b0;
    #1 check("rob_async_reset", outs_vec(), 9'h000);
    tick();
    ARESETN = 1'b1;
    tick();
    check("rob_after_rerelease", outs_vec(), exp_vec(3'd0));
  endtask

  // ---------------- random traffic + timeline model ----------------
  // Expected state from absolute timestamps of the swap milestones.
  function automatic logic [2:0] model_state(input int mode, input int c, input int t_b, input int t_f);
    int d;
    case (mode)
      0: return 3'd0;
      1: return 3'd1;
      2: return (c == t_b) ? 3'd2 : 3'd3;
      4: return 3'd7;
      default: begin
        d = c - t_f;
        if (d < RST) return 3'd4;
        if (d < RST + SETTLE) return 3'd5;
        if (d == RST + SETTLE) return 3'd6;
        return 3'd0;
      end
    endcase
  endfunction

  task automatic run_random(input int n_cyc);
    logic [8:0] exp_q[$];
    logic [7:0] in;
    logic [2:0] prev_st, new_st;
    logic       hs, sof, last;
    int         c, mode, t_drain, t_b, t_f, lines;
    do_reset();
    c = 0; mode = 0; t_drain = 0; t_b = 0; t_f = 0; lines = 0;
    for (int k = 0; k < n_cyc; k++) begin
      in = 8'h00;
      if ($urandom_range(7) == 0)  in |= I_START;
      if ($urandom_range(7) == 0)  in |= I_CLEAR;
      if ($urandom_range(3) != 0)  in |= I_VAL;
      if ($urandom_range(3) != 0)  in |= I_RDY;
      if ($urandom_range(1) == 0)  in |= I_LAST;
      if ($urandom_range(15) == 0) in |= I_SOF;
      if ($urandom_range(9) == 0)  in |= I_LDONE;
      if ($urandom_range(39) == 0) in |= I_LERR;
      drive(in);

      prev_st = model_state(mode, c, t_b, t_f);
      hs   = in[5] & in[4];
      sof  = in[2];
      last = in[3];
      case (mode)
        0: if (in[7]) begin mode = 1; t_drain = c + 1; end
        1: begin
          if (lines == LPF && !(hs && sof)) begin mode = 2; t_b = c + 1; end
          else if (c + 1 - t_drain == TO) mode = 4;
        end
        2: if (prev_st == 3'd3) begin
          if (in[0]) mode = 4;
          else if (in[1]) begin mode = 3; t_f = c + 1; end
          else if (c + 1 - (t_b + 1) == TO) mode = 4;
        end
        4: if (in[6]) mode = 0;
        default: ;
      endcase
      c++;
      if (mode == 3 && c - t_f > RST + SETTLE) mode = 0;
      new_st = model_state(mode, c, t_b, t_f);

      if (new_st == 3'd5 && prev_st != 3'd5) lines = 0;
      else if (hs && sof) lines = last ? 1 : 0;
      else if (hs && last && lines < LPF) lines++;

      exp_q.push_back(exp_vec(new_st));
      tick();
      check($sformatf("rand_c%0d", c), outs_vec(), exp_q.pop_front());
    end
    drive(8'h00);
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    ARESETN = 1'b0;
    drive(8'h00);
    repeat (10) @(posedge ACLK);
    #1;
    check("reset_values", outs_vec(), 9'h000);
    ARESETN = 1'b1;
    #1 check("rstn_low_until_edge", rp_resetn_o, 1'b0);
    tick();
    check("after_reset_release", outs_vec(), exp_vec(3'd0));

    run_table();
    run_nominal();
    run_timeouts();
    run_robustness();
    run_random(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
